// File: rtl/adder_tree_pipelined.sv
// adder_tree_pipelined: N-operand registered binary reduction tree with
// valid/ready flow control and an exact, full-precision sum.
module adder_tree_pipelined #(
  parameter int NUM_INPUTS     = 4,
  parameter int WIDTH          = 8,
  parameter int SIGNED         = 0,
  parameter int REGISTER_INPUT = 0,
  localparam int OUT_WIDTH     = WIDTH + $clog2(NUM_INPUTS),
  localparam int LEVELS        = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OUT_WIDTH-1:0]        out_sum,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam logic SX = (SIGNED != 0);

  logic adv;

  // One global enable: the whole chain moves together or holds together.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned W   = WIDTH + k;
    localparam int unsigned CNT = (NUM_INPUTS + (1 << k) - 1) >> k;

    logic [W-1:0] data [CNT];
    logic         vld;

    if (k == 0) begin : g_src
      if (REGISTER_INPUT != 0) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld <= 1'b0;
            for (int unsigned i = 0; i < CNT; i++) data[i] <= '0;
          end else if (adv) begin
            vld <= in_valid;
            for (int unsigned i = 0; i < CNT; i++) data[i] <= in_data[i*WIDTH +: WIDTH];
          end
        end
      end else begin : g_comb
        assign vld = in_valid;
        for (genvar i = 0; i < CNT; i++) begin : g_op
          assign data[i] = in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin : g_red
      localparam int unsigned PCNT = (NUM_INPUTS + (1 << (k - 1)) - 1) >> (k - 1);

      logic [W-1:0] nxt [CNT];

      for (genvar j = 0; j < CNT; j++) begin : g_node
        logic [W-2:0] a;
        assign a = g_lvl[k-1].data[2*j];
        if (2*j + 1 < PCNT) begin : g_add
          logic [W-2:0] b;
          assign b      = g_lvl[k-1].data[2*j+1];
          assign nxt[j] = {SX & a[W-2], a} + {SX & b[W-2], b};
        end else begin : g_pass
          // Odd trailing element: widen only, no add.
          assign nxt[j] = {SX & a[W-2], a};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
          for (int unsigned i = 0; i < CNT; i++) data[i] <= '0;
        end else if (adv) begin
          vld <= g_lvl[k-1].vld;
          for (int unsigned i = 0; i < CNT; i++) data[i] <= nxt[i];
        end
      end
    end
  end

  assign out_sum   = g_lvl[LEVELS].data[0];
  assign out_valid = g_lvl[LEVELS].vld;

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Self-checking bench for adder_tree_pipelined: directed vectors on small
// configurations plus a randomized, scoreboarded stream on a 4-operand tree.
module tb_adder_tree_pipelined;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-operand, 8-bit unsigned stream instance
  logic [31:0] in_data4;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [9:0]  out_sum4;

  // small directed instances
  logic        small_ready;
  logic [23:0] d3u, d3r, d3s;
  logic [19:0] d5;
  logic        v3u, v3r, v3s, v5;
  logic        r3u, r3r, r3s, r5;
  logic        ov3u, ov3r, ov3s, ov5;
  logic [9:0]  s3u, s3r, s3s;
  logic [6:0]  s5;

  adder_tree_pipelined #(.NUM_INPUTS(4), .WIDTH(8), .SIGNED(0), .REGISTER_INPUT(0)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_sum(out_sum4), .out_valid(out_valid4), .out_ready(out_ready4));

  adder_tree_pipelined #(.NUM_INPUTS(3), .WIDTH(8), .SIGNED(0), .REGISTER_INPUT(0)) u_n3u (
    .clk(clk), .rst_n(rst_n), .in_data(d3u), .in_valid(v3u), .in_ready(r3u),
    .out_sum(s3u), .out_valid(ov3u), .out_ready(small_ready));

  adder_tree_pipelined #(.NUM_INPUTS(3), .WIDTH(8), .SIGNED(0), .REGISTER_INPUT(1)) u_n3r (
    .clk(clk), .rst_n(rst_n), .in_data(d3r), .in_valid(v3r), .in_ready(r3r),
    .out_sum(s3r), .out_valid(ov3r), .out_ready(small_ready));

  adder_tree_pipelined #(.NUM_INPUTS(3), .WIDTH(8), .SIGNED(1), .REGISTER_INPUT(0)) u_n3s (
    .clk(clk), .rst_n(rst_n), .in_data(d3s), .in_valid(v3s), .in_ready(r3s),
    .out_sum(s3s), .out_valid(ov3s), .out_ready(small_ready));

  adder_tree_pipelined #(.NUM_INPUTS(5), .WIDTH(4), .SIGNED(0), .REGISTER_INPUT(0)) u_n5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5), .in_valid(v5), .in_ready(r5),
    .out_sum(s5), .out_valid(ov5), .out_ready(small_ready));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // cfg: 0 = N3 unsigned, 1 = N3 registered input, 2 = N3 signed, 3 = N5 W4
  typedef struct {
    int cfg;
    int op[5];
    int exp_sum;
    int exp_lat;
  } vec_t;

  function automatic vec_t mkv(input int cfg, input int a, input int b, input int c,
                               input int d, input int e, input int s, input int lat);
    vec_t v;
    v.cfg = cfg;
    v.op[0] = a; v.op[1] = b; v.op[2] = c; v.op[3] = d; v.op[4] = e;
    v.exp_sum = s;
    v.exp_lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [39:0] bus;
    int  n, got;
    bit  seen;
    logic rdy;
    bus = '0;
    for (int i = 0; i < 5; i++) begin
      if (v.cfg == 3) bus[i*4 +: 4] = 4'(v.op[i]);
      else            bus[i*8 +: 8] = 8'(v.op[i]);
    end
    d3u = bus[23:0]; d3r = bus[23:0]; d3s = bus[23:0]; d5 = bus[19:0];
    case (v.cfg)
      0:       v3u = 1'b1;
      1:       v3r = 1'b1;
      2:       v3s = 1'b1;
      default: v5  = 1'b1;
    endcase
    #1;
    case (v.cfg)
      0:       rdy = r3u;
      1:       rdy = r3r;
      2:       rdy = r3s;
      default: rdy = r5;
    endcase
    chk($sformatf("vec%0d_in_ready", idx), int'(rdy), 1);
    n = 0;
    seen = 1'b0;
    got = 0;
    // latency counts edges from (and including) the accepting edge
    while (!seen && n < 8) begin
      @(posedge clk);
      #1;
      if (n == 0) begin v3u = 1'b0; v3r = 1'b0; v3s = 1'b0; v5 = 1'b0; end
      n++;
      case (v.cfg)
        0:       begin seen = ov3u; got = int'(s3u); end
        1:       begin seen = ov3r; got = int'(s3r); end
        2:       begin seen = ov3s; got = int'($signed(s3s)); end
        default: begin seen = ov5;  got = int'(s5); end
      endcase
    end
    chk($sformatf("vec%0d_valid_seen", idx), int'(seen), 1);
    chk($sformatf("vec%0d_latency", idx), n, v.exp_lat);
    if (seen) chk($sformatf("vec%0d_sum", idx), got, v.exp_sum);
    repeat (3) @(negedge clk);
  endtask

  // Reference: plain sum of the four unsigned bytes.
  function automatic int ref4(input logic [31:0] d);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(d[i*8 +: 8]);
    return s;
  endfunction

  int          exp_q[$];
  int          got_q[$];
  bit          hold_pend;
  logic [9:0]  held;

  // Called at a negedge after inputs are set; checks, then advances to next negedge.
  task automatic step4(output bit acc);
    #1;
    chk("in_ready_rule", int'(in_ready4), int'(out_ready4 || !out_valid4));
    if (hold_pend) begin
      chk("stall_valid_held", int'(out_valid4), 1);
      chk("stall_sum_held", int'(out_sum4), int'(held));
    end
    hold_pend = out_valid4 && !out_ready4;
    held      = out_sum4;
    if (out_valid4 && out_ready4) begin
      if (exp_q.size() == 0) chk("spurious_out", int'(out_valid4), 0);
      else begin
        got_q.push_back(int'(out_sum4));
        chk("stream_sum", int'(out_sum4), exp_q.pop_front());
      end
    end
    acc = in_valid4 && in_ready4;
    if (acc) exp_q.push_back(ref4(in_data4));
    @(negedge clk);
  endtask

  vec_t        vecs[9];
  logic [31:0] bp[4];

  initial begin
    bit acc;
    int idx, stalls, lows, guard;

    vecs[0] = mkv(0,  255,  255,  255, 0, 0,  765, 2);
    vecs[1] = mkv(1,  255,  255,  255, 0, 0,  765, 3);
    vecs[2] = mkv(2, -128, -128, -128, 0, 0, -384, 2);
    vecs[3] = mkv(2,  127,   -1,    0, 0, 0,  126, 2);
    vecs[4] = mkv(3,    1,    2,    3, 4, 15,  25, 3);
    vecs[5] = mkv(3,   15,   15,   15, 15, 15, 75, 3);
    vecs[6] = mkv(1,    1,    0,    2, 0, 0,    3, 3);
    vecs[7] = mkv(2,  127,  127,  127, 0, 0,  381, 2);
    vecs[8] = mkv(2,   -1,   -1,   -1, 0, 0,   -3, 2);

    rst_n = 1'b0;
    in_valid4 = 1'b1; in_data4 = 32'h11223344; out_ready4 = 1'b0;
    small_ready = 1'b1;
    d3u = '0; d3r = '0; d3s = '0; d5 = '0;
    v3u = 1'b1; v3r = 1'b1; v3s = 1'b1; v5 = 1'b1;
    hold_pend = 1'b0; held = '0;

    // beats presented during reset must not be captured
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid4), 0);
      chk("rst_out_sum", int'(out_sum4), 0);
      chk("rst_in_ready", int'(in_ready4), 1);
    end
    chk("rst_n5_valid", int'(ov5), 0);
    chk("rst_n3r_valid", int'(ov3r), 0);
    rst_n = 1'b1;
    in_valid4 = 1'b0;
    v3u = 1'b0; v3r = 1'b0; v3s = 1'b0; v5 = 1'b0;
    out_ready4 = 1'b1;
    repeat (5) step4(acc);
    chk("post_rst_idle", int'(out_valid4), 0);
    chk("post_rst_n3r_idle", int'(ov3r), 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // randomized stream against the scoreboard
    for (int c = 0; c < 400; c++) begin
      in_valid4  = ($urandom_range(0, 3) != 0);
      in_data4   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      out_ready4 = ($urandom_range(0, 2) != 0);
      step4(acc);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    repeat (6) step4(acc);
    chk("drain_empty", exp_q.size(), 0);

    // backpressure: stall three cycles while 20 is presented
    bp[0] = 32'h0403_0201; bp[1] = 32'h0505_0505; bp[2] = 32'h1E00_0000; bp[3] = 32'h0A0A_0A0A;
    got_q.delete();
    idx = 0; stalls = 0; lows = 0; guard = 0;
    while ((idx < 4 || exp_q.size() != 0) && guard < 40) begin
      guard++;
      in_valid4 = (idx < 4);
      in_data4  = bp[(idx < 4) ? idx : 0];
      if (out_valid4 && out_sum4 == 10'd20 && stalls < 3) begin
        out_ready4 = 1'b0;
        stalls++;
      end else out_ready4 = 1'b1;
      #1;
      if (!out_ready4) chk("bp_in_ready_low", int'(in_ready4), 0);
      if (!in_ready4) lows++;
      step4(acc);
      if (acc) idx++;
    end
    in_valid4 = 1'b0;
    chk("bp_stall_cycles", stalls, 3);
    chk("bp_in_ready_low_cycles", lows, 3);
    chk("bp_output_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk($sformatf("bp_seq%0d", i), got_q[i], 10 * (i + 1));

    // asynchronous reset with two sets in flight
    out_ready4 = 1'b1;
    in_valid4 = 1'b1; in_data4 = 32'h0101_0101; step4(acc);
    in_data4 = 32'h0202_0202; step4(acc);
    in_valid4 = 1'b0;
    chk("pre_rst_valid", int'(out_valid4), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid4), 0);
    chk("async_rst_sum", int'(out_sum4), 0);
    chk("async_rst_in_ready", int'(in_ready4), 1);
    exp_q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step4(acc);
    chk("post_async_rst_idle", int'(out_valid4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipelined.md
# adder_tree_pipelined

Parametrised N-operand adder built as a registered binary reduction tree, with valid/ready flow control and full-precision output. It generalises the fixed three-input adder to any operand count ≥2 and adds signed/unsigned operation, per-level pipelining and backpressure. It sits in arithmetic datapaths such as dot-product reductions and filter tap sums, between a streaming producer and consumer.

## Interface
- NUM_INPUTS, 4, operand count; legal range 2–64.
- WIDTH, 8, bits per operand; 1–32.
- SIGNED, 0, 1 = two's-complement operands and result; 0 = unsigned.
- REGISTER_INPUT, 0, 1 = extra register stage in front of the tree.
- OUT_WIDTH (localparam), WIDTH + $clog2(NUM_INPUTS), full-precision result width.
- LEVELS (localparam), $clog2(NUM_INPUTS), tree depth.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_INPUTS*WIDTH  operands; operand i = in_data[i*WIDTH +: WIDTH].
- in_valid  in  1  in_data holds a valid operand set.
- in_ready  out  1  block accepts in_data this cycle.
- out_sum  out  OUT_WIDTH  sum of the accepted operand set.
- out_valid  out  1  out_sum is valid.
- out_ready  in  1  consumer accepts out_sum this cycle.

## Operation
- Transfer rule (both sides): a beat moves when valid && ready are both high on a rising edge.
- Global advance enable: adv = out_ready || !out_valid. in_ready = adv (combinational). When adv = 0, every stage holds its data and valid bit.
- Stage chain: optional input stage (REGISTER_INPUT=1), then LEVELS tree levels, each with a data register set and one valid bit. The last level's registers drive out_sum and out_valid directly.
- On adv: stage 0 loads in_data and captures in_valid; stage k+1 loads the stage-k result and valid bit. Bubbles (valid=0) propagate like data and are not collapsed.
- Level k (1-based) input width WIDTH+k-1, output width WIDTH+k. Element j = elem[2j] + elem[2j+1], each operand sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to WIDTH+k before adding. An odd trailing element passes through extended, with no add.
- Final level output is extended to OUT_WIDTH. The result is exact: no overflow is possible at any NUM_INPUTS in range.
- NUM_INPUTS that is not a power of two uses the pass-through rule; the result is identical to the mathematical sum.
- Reset (asserted at any time, including mid-stream or mid-stall): all valid bits clear to 0, all data registers clear to 0, out_sum = 0, out_valid = 0. In-flight sets are discarded. in_ready = 1 while reset is held, because out_valid = 0; beats presented during reset are not captured.
- First capture is on the first rising edge after rst_n deasserts.

## Timing
- Latency, accepted beat to out_valid: LEVELS + REGISTER_INPUT cycles when not stalled. Examples: N=2 → 1; N=3 or 4 → 2; N=5 → 3; add 1 when REGISTER_INPUT=1.
- Throughput: one operand set per cycle when out_ready is held high.
- Stall: out_valid=1 && out_ready=0 drops in_ready in the same cycle. out_sum stays stable until the transfer.
- Simultaneous out transfer and in accept: both complete on the same edge; there is no bubble.
- out_valid=0 with out_ready=0: adv = 1, so the pipeline keeps filling.

## Test plan
- Reset values: hold rst_n=0 and drive in_valid=1 with data → out_valid=0, out_sum=0, in_ready=1, and nothing emerges after release until a new beat is accepted.
- Unsigned max, N=3, WIDTH=8: operands 255,255,255 → out_sum=765 (10 bits) exactly 2 cycles after accept; with REGISTER_INPUT=1, 3 cycles.
- Signed, N=3, WIDTH=8, SIGNED=1: -128,-128,-128 → out_sum=10'h280 (-384). Then 127,-1,0 → 126.
- Odd count, N=5, WIDTH=4, unsigned: 1,2,3,4,15 → out_sum=25 (7 bits), latency 3.
- Backpressure, N=4: stream sets summing to 10,20,30,40 back-to-back and drop out_ready for 3 cycles while out_sum=20 → in_ready low for exactly those cycles, out_sum holds 20, the sequence completes 10,20,30,40 with none lost or duplicated.
- Reset mid-stream: assert rst_n low asynchronously between edges with 2 sets in flight → out_valid falls immediately, and no stale sum appears after release.
